// File: rtl/key_search_pkg.sv
// -----------------------------------------------------------------------------
// key_search_pkg
// Shared types and constants for the RC4 key-search datapath.
//   KEY_W_DEFAULT : default secret-key width in bits
//   N_CH_DEFAULT  : default number of decrypt cores
//   ks_state_t    : dispatcher state encoding (IDLE, RUN, DRAIN, DONE)
// -----------------------------------------------------------------------------
package key_search_pkg;

    localparam int KEY_W_DEFAULT = 24;
    localparam int N_CH_DEFAULT  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ks_state_t;

endpackage

// File: rtl/key_range_dispatcher_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a one-hot combinational grant. The search for a
// requester starts at the internal pointer. After a grant the pointer moves to
// one past the granted index, so every requester is reached within N grants.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset (pointer returns to 0)
//   req   : request vector
//   en    : grant enable; with en low, gnt is 0 and the pointer holds
//   gnt   : one-hot grant (or 0)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             hit;
    int               idx;

    // Scan the requesters in rotating order, starting at the pointer.
    // The first active request wins. The pointer then moves past the winner.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        hit   = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (en && !hit && req[idx]) begin
                gnt[idx] = 1'b1;
                hit      = 1'b1;
                ptr_d    = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    // Pointer register. It is cleared asynchronously on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/key_range_dispatcher.sv
// -----------------------------------------------------------------------------
// key_range_dispatcher
// Key-candidate source for the RC4 codebreaker. It walks the inclusive range
// [key_lo, key_hi] and deals one key per cycle at most to N_CH decrypt cores,
// using round-robin arbitration. The search ends on the first hit, on abort,
// or when the range is used up and all keys in flight have retired.
// Ports:
//   clk, reset    : clock (rising edge) and async active-low reset
//   start         : begins a search when not busy; latches key_lo/key_hi
//   abort         : ends the search with no hit
//   key_lo/key_hi : inclusive key range
//   ch_req        : per-core request for a new key (also retires previous key)
//   ch_found      : per-core hit pulse
//   ch_found_key  : per-core reported key, slice i = [i*KEY_W +: KEY_W]
//   ch_gnt/ch_key : registered one-hot grant and the key that goes with it
//   busy          : high in RUN and DRAIN
//   done/found    : search finished / finished with a hit
//   found_key     : winning key
//   keys_issued   : number of keys granted since the last accepted start
// -----------------------------------------------------------------------------
module key_range_dispatcher
    import key_search_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEFAULT,
    parameter int N_CH  = N_CH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KEY_W-1:0]      key_lo,
    input  logic [KEY_W-1:0]      key_hi,
    input  logic [N_CH-1:0]       ch_req,
    input  logic [N_CH-1:0]       ch_found,
    input  logic [N_CH*KEY_W-1:0] ch_found_key,
    output logic [N_CH-1:0]       ch_gnt,
    output logic [KEY_W-1:0]      ch_key,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [KEY_W-1:0]      found_key,
    output logic [KEY_W:0]        keys_issued
);

    ks_state_t         state_q, state_d;
    logic [KEY_W-1:0]  next_key_q, next_key_d;
    logic [KEY_W-1:0]  key_hi_q, key_hi_d;
    logic [N_CH-1:0]   outstanding_q, outstanding_d;
    logic [N_CH-1:0]   ch_gnt_q, ch_gnt_d;
    logic [KEY_W-1:0]  ch_key_q, ch_key_d;
    logic              done_q, done_d;
    logic              found_q, found_d;
    logic [KEY_W-1:0]  found_key_q, found_key_d;
    logic [KEY_W:0]    keys_issued_q, keys_issued_d;

    logic [N_CH-1:0]   arb_req;
    logic [N_CH-1:0]   arb_gnt;
    logic              arb_en;
    logic [KEY_W-1:0]  hit_key;

    // A core that sees its grant this cycle is masked, so it cannot get two
    // keys back to back. Grants are also blocked in any cycle that ends the search.
    assign arb_req = ch_req & ~ch_gnt_q;
    assign arb_en  = (state_q == RUN) && (ch_found == '0) && !abort;

    rr_arbiter #(
        .N (N_CH)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (arb_req),
        .en    (arb_en),
        .gnt   (arb_gnt)
    );

    // Scanning from the top index down means the lowest reporting core wins.
    always_comb begin
        hit_key = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_found[i]) begin
                hit_key = ch_found_key[i*KEY_W +: KEY_W];
            end
        end
    end

    // Next-state and datapath logic. The last key is detected by equality
    // with key_hi. next_key is never incremented past it, so a range that
    // ends at the all-ones key cannot wrap round to 0.
    always_comb begin
        state_d       = state_q;
        next_key_d    = next_key_q;
        key_hi_d      = key_hi_q;
        outstanding_d = outstanding_q & ~(ch_req | ch_found);
        ch_gnt_d      = '0;
        ch_key_d      = '0;
        done_d        = done_q;
        found_d       = found_q;
        found_key_d   = found_key_q;
        keys_issued_d = keys_issued_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    found_d       = 1'b0;
                    found_key_d   = '0;
                    keys_issued_d = '0;
                    outstanding_d = '0;
                    if (key_lo <= key_hi) begin
                        state_d    = RUN;
                        done_d     = 1'b0;
                        next_key_d = key_lo;
                        key_hi_d   = key_hi;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (ch_found != '0) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    found_d     = 1'b1;
                    found_key_d = hit_key;
                end else if (abort) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    found_d = 1'b0;
                end else if (arb_gnt != '0) begin
                    ch_gnt_d      = arb_gnt;
                    ch_key_d      = next_key_q;
                    outstanding_d = outstanding_d | arb_gnt;
                    keys_issued_d = keys_issued_q + 1'b1;
                    if (next_key_q == key_hi_q) begin
                        state_d = DRAIN;
                    end else begin
                        next_key_d = next_key_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (ch_found != '0) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    found_d     = 1'b1;
                    found_key_d = hit_key;
                end else if (abort || (outstanding_q == '0)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    found_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears them all asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            next_key_q    <= '0;
            key_hi_q      <= '0;
            outstanding_q <= '0;
            ch_gnt_q      <= '0;
            ch_key_q      <= '0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            found_key_q   <= '0;
            keys_issued_q <= '0;
        end else begin
            state_q       <= state_d;
            next_key_q    <= next_key_d;
            key_hi_q      <= key_hi_d;
            outstanding_q <= outstanding_d;
            ch_gnt_q      <= ch_gnt_d;
            ch_key_q      <= ch_key_d;
            done_q        <= done_d;
            found_q       <= found_d;
            found_key_q   <= found_key_d;
            keys_issued_q <= keys_issued_d;
        end
    end

    assign ch_gnt      = ch_gnt_q;
    assign ch_key      = ch_key_q;
    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign done        = done_q;
    assign found       = found_q;
    assign found_key   = found_key_q;
    assign keys_issued = keys_issued_q;

endmodule

// File: tb/tb_key_range_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_key_range_dispatcher
// Directed testbench for key_range_dispatcher. It uses a 4-core instance for
// most scenarios and a 1-core instance for the single-channel walk.
// -----------------------------------------------------------------------------
module tb_key_range_dispatcher;

    localparam int KW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            start, start1, abort;
    logic [KW-1:0]   key_lo, key_hi;

    logic [3:0]      ch_req, ch_found;
    logic [4*KW-1:0] ch_found_key;
    logic [3:0]      ch_gnt;
    logic [KW-1:0]   ch_key, found_key;
    logic            busy, done, found;
    logic [KW:0]     keys_issued;

    logic [0:0]      ch_req1, ch_found1, ch_gnt1;
    logic [KW-1:0]   ch_found_key1, ch_key1, found_key1;
    logic            busy1, done1, found1;
    logic [KW:0]     keys_issued1;

    int checks   = 0;
    int failures = 0;

    logic [KW-1:0] gkey[$];
    int            gidx[$];
    logic [3:0]    gnt_seen;

    key_range_dispatcher #(.KEY_W(KW), .N_CH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .key_lo(key_lo), .key_hi(key_hi), .ch_req(ch_req), .ch_found(ch_found),
        .ch_found_key(ch_found_key), .ch_gnt(ch_gnt), .ch_key(ch_key),
        .busy(busy), .done(done), .found(found), .found_key(found_key),
        .keys_issued(keys_issued)
    );

    key_range_dispatcher #(.KEY_W(KW), .N_CH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort),
        .key_lo(key_lo), .key_hi(key_hi), .ch_req(ch_req1), .ch_found(ch_found1),
        .ch_found_key(ch_found_key1), .ch_gnt(ch_gnt1), .ch_key(ch_key1),
        .busy(busy1), .done(done1), .found(found1), .found_key(found_key1),
        .keys_issued(keys_issued1)
    );

    // Count one comparison and report it when it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one clock on the selected instance.
    task automatic applyStimulus(input bit use1, input logic [KW-1:0] lo,
                                 input logic [KW-1:0] hi);
        key_lo = lo;
        key_hi = hi;
        if (use1) start1 = 1'b1;
        else      start  = 1'b1;
        tick();
        start  = 1'b0;
        start1 = 1'b0;
    endtask

    // Record every grant until done rises. The wait is bounded by a cycle budget.
    task automatic collectGrants(input bit use1, input int budget);
        logic seen_done;
        gkey.delete();
        gidx.delete();
        seen_done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (use1) begin
                if (ch_gnt1 != '0) begin
                    gkey.push_back(ch_key1);
                    gidx.push_back(1);
                end
                seen_done = done1;
            end else begin
                if (ch_gnt != '0) begin
                    gkey.push_back(ch_key);
                    gidx.push_back(int'(ch_gnt));
                end
                seen_done = done;
            end
            if (seen_done) break;
            tick();
        end
        checkOutput("done_within_budget", 32'(seen_done), 32'd1);
    endtask

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        start1        = 1'b0;
        abort         = 1'b0;
        key_lo        = '0;
        key_hi        = '0;
        ch_req        = '0;
        ch_found      = '0;
        ch_found_key  = '0;
        ch_req1       = '0;
        ch_found1     = '0;
        ch_found_key1 = '0;

        tick();
        tick();
        checkOutput("rst_gnt",         32'(ch_gnt),      32'd0);
        checkOutput("rst_busy",        32'(busy),        32'd0);
        checkOutput("rst_done",        32'(done),        32'd0);
        checkOutput("rst_found",       32'(found),       32'd0);
        checkOutput("rst_keys_issued", 32'(keys_issued), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single core, req held: keys 5..8, one grant every other cycle.
        ch_req1 = 1'b1;
        applyStimulus(1'b1, 24'd5, 24'd8);
        checkOutput("t1_busy", 32'(busy1), 32'd1);
        collectGrants(1'b1, 40);
        checkOutput("t1_count", 32'(gkey.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            checkOutput("t1_key", (i < gkey.size()) ? 32'(gkey[i]) : 32'hDEAD, 32'(5 + i));
        checkOutput("t1_found",       32'(found1),       32'd0);
        checkOutput("t1_keys_issued", 32'(keys_issued1), 32'd4);
        ch_req1 = 1'b0;

        // Four cores, all requesting: rotation 0,1,2,3,0,1,2,3 with keys 0..7.
        ch_req = 4'hF;
        applyStimulus(1'b0, 24'd0, 24'd7);
        collectGrants(1'b0, 40);
        checkOutput("t2_count", 32'(gkey.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t2_gnt", (i < gidx.size()) ? 32'(gidx[i]) : 32'hDEAD, 32'(1 << (i % 4)));
            checkOutput("t2_key", (i < gkey.size()) ? 32'(gkey[i]) : 32'hDEAD, 32'(i));
        end
        checkOutput("t2_found",       32'(found),       32'd0);
        checkOutput("t2_keys_issued", 32'(keys_issued), 32'd8);

        // All-ones single-key range: exactly one grant, no wrap to 0.
        ch_req = 4'b0001;
        applyStimulus(1'b0, 24'hFFFFFF, 24'hFFFFFF);
        collectGrants(1'b0, 40);
        checkOutput("t3_count", 32'(gkey.size()), 32'd1);
        checkOutput("t3_key", (gkey.size() > 0) ? 32'(gkey[0]) : 32'hDEAD, 32'hFFFFFF);
        checkOutput("t3_keys_issued", 32'(keys_issued), 32'd1);
        checkOutput("t3_found",       32'(found),       32'd0);

        // Two hits in the same cycle: the lower index wins and no grant is issued.
        ch_req = 4'h0;
        applyStimulus(1'b0, 24'h100, 24'hFFFF);
        checkOutput("t4_busy", 32'(busy), 32'd1);
        ch_req       = 4'hF;
        ch_found     = 4'b0110;
        ch_found_key = {24'h0, 24'h1234, 24'h0ABC, 24'h0};
        tick();
        ch_found = '0;
        ch_req   = '0;
        checkOutput("t4_done",        32'(done),        32'd1);
        checkOutput("t4_found",       32'(found),       32'd1);
        checkOutput("t4_found_key",   32'(found_key),   32'h0ABC);
        checkOutput("t4_gnt",         32'(ch_gnt),      32'd0);
        checkOutput("t4_keys_issued", 32'(keys_issued), 32'd0);

        // Inverted range: done with no hit and never a grant.
        ch_req   = 4'hF;
        gnt_seen = '0;
        applyStimulus(1'b0, 24'd9, 24'd3);
        for (int c = 0; c < 4; c++) begin
            gnt_seen = gnt_seen | ch_gnt;
            tick();
        end
        checkOutput("t5_done",        32'(done),        32'd1);
        checkOutput("t5_found",       32'(found),       32'd0);
        checkOutput("t5_gnt_never",   32'(gnt_seen),    32'd0);
        checkOutput("t5_keys_issued", 32'(keys_issued), 32'd0);

        // Abort partway through RUN after three grants.
        applyStimulus(1'b0, 24'd0, 24'd100);
        tick();
        tick();
        tick();
        checkOutput("t5_abort_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t5_abort_done",  32'(done),        32'd1);
        checkOutput("t5_abort_found", 32'(found),       32'd0);
        checkOutput("t5_abort_idle",  32'(busy),        32'd0);
        checkOutput("t5_abort_keys",  32'(keys_issued), 32'd3);

        // Abort and hit in the same cycle: the hit takes priority.
        applyStimulus(1'b0, 24'd0, 24'd100);
        abort        = 1'b1;
        ch_found     = 4'b1000;
        ch_found_key = {24'h777, 72'h0};
        tick();
        abort    = 1'b0;
        ch_found = '0;
        checkOutput("t5_both_found",     32'(found),     32'd1);
        checkOutput("t5_both_found_key", 32'(found_key), 32'h777);

        // Async reset while a grant is on the outputs, then a fresh search.
        applyStimulus(1'b0, 24'd5, 24'd100);
        tick();
        checkOutput("t6_gnt_pending", 32'(ch_gnt != '0), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("t6_rst_gnt",  32'(ch_gnt),      32'd0);
        checkOutput("t6_rst_key",  32'(ch_key),      32'd0);
        checkOutput("t6_rst_busy", 32'(busy),        32'd0);
        checkOutput("t6_rst_keys", 32'(keys_issued), 32'd0);
        @(negedge clk);
        reset  = 1'b1;
        ch_req = 4'b0001;
        applyStimulus(1'b0, 24'h10, 24'h11);
        collectGrants(1'b0, 40);
        checkOutput("t6_count", 32'(gkey.size()), 32'd2);
        checkOutput("t6_key0", (gkey.size() > 0) ? 32'(gkey[0]) : 32'hDEAD, 32'h10);
        checkOutput("t6_key1", (gkey.size() > 1) ? 32'(gkey[1]) : 32'hDEAD, 32'h11);
        checkOutput("t6_keys_issued", 32'(keys_issued), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
